// File: rtl/nand_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_arb_pkg : shared constants and helpers for the NAND arbiter      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package nand_arb_pkg;
  localparam int NUM_REQ_DEFAULT = 4;
  localparam int OP_CNT_W        = 16;
  localparam logic [OP_CNT_W-1:0] OP_CNT_MAX = '1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/nand_rr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick  : combinational first-one picker scanning from ptr upward    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_valid
);
  int idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any_valid && valid[idx]) begin
        any_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/nand_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_rr_arbiter : round-robin access to a registered bitwise NAND     |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module nand_rr_arbiter
  import nand_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int WIDTH   = 1,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic [OP_CNT_W-1:0]      op_count,
  output logic                     busy
);
  logic                rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]    rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
  logic [ID_W-1:0]     ptr_q,       ptr_d;
  logic [OP_CNT_W-1:0] op_count_q,  op_count_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                any_valid;
  logic                can_accept, accept, drain;
  logic [WIDTH-1:0]    sel_a, sel_b;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    can_accept  = !rsp_valid_q || rsp_ready;
    drain       = rsp_valid_q && rsp_ready;
    accept      = any_valid && can_accept && !rst;
    req_ready   = (rst || !can_accept) ? '0 : gnt;

    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    op_count_d  = op_count_q;

    // An accept on a draining edge overwrites the register, so no bubble.
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = ~(sel_a & sel_b);
      rsp_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (drain) begin
      rsp_valid_d = 1'b0;
    end

    if (drain && op_count_q != OP_CNT_MAX)
      op_count_d = op_count_q + OP_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
      op_count_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign busy      = rsp_valid_q || (|req_valid);
endmodule
`default_nettype wire

// File: tb/tb_nand_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nand_rr_arbiter : directed tables plus randomized model checking   |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_nand_rr_arbiter;
  localparam int N = 4;
  localparam int W = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic [15:0]    op_count;
  logic           busy;

  nand_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .op_count  (op_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected contents of the result register and counters.
  bit         m_init = 1'b0;
  bit         m_full;
  logic [W-1:0] m_data;
  int         m_id, m_ptr, m_cnt, m_last_acc;

  typedef struct { logic a; logic b; logic exp; } nand_vec_t;
  nand_vec_t tv[4];
  int order[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: check DUT against the model at the falling edge, advance the model.
  task automatic tick();
    int w, j;
    bit can, drn;
    logic [N-1:0] er;
    @(negedge clk);
    w = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (w < 0 && req_valid[j]) w = j;
    end
    can = !m_full || rsp_ready;
    er  = '0;
    if (!rst && can && w >= 0) er[w] = 1'b1;
    if (m_init) begin
      chk("model_req_ready", 32'(req_ready), 32'(er));
      chk("model_rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full) begin
        chk("model_rsp_data", 32'(rsp_data), 32'(m_data));
        chk("model_rsp_id", 32'(rsp_id), 32'(m_id));
      end
      chk("model_op_count", 32'(op_count), 32'(m_cnt));
      chk("model_busy", 32'(busy), 32'(m_full || (|req_valid)));
    end
    m_last_acc = -1;
    if (rst) begin
      m_full = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
      m_init = 1'b1;
    end else begin
      drn = m_full && rsp_ready;
      if (drn && m_cnt < 65535) m_cnt++;
      if (can && w >= 0) begin
        m_full = 1'b1;
        m_data = ~(req_a[w*W +: W] & req_b[w*W +: W]);
        m_id   = w;
        m_ptr  = (w + 1) % N;
        m_last_acc = w;
      end else if (drn) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tv[0] = '{a: 1'b0, b: 1'b0, exp: 1'b1};
    tv[1] = '{a: 1'b0, b: 1'b1, exp: 1'b1};
    tv[2] = '{a: 1'b1, b: 1'b0, exp: 1'b1};
    tv[3] = '{a: 1'b1, b: 1'b1, exp: 1'b0};
    order = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Reset: two cycles with everyone requesting.
    tick();
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    tick();
    chk("reset_req_ready2", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_op_count", 32'(op_count), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_reset_grant0", 32'(req_ready), 32'h1);
    tick();
    chk("post_reset_rsp_id", 32'(rsp_id), 32'h0);

    // NAND truth table via requester 2.
    req_valid = '0;
    do_reset();
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      req_a[2] = tv[i].a;
      req_b[2] = tv[i].b;
      tick();
      chk("nand_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("nand_rsp_data", 32'(rsp_data), 32'(tv[i].exp));
      chk("nand_rsp_id", 32'(rsp_id), 32'h2);
    end
    req_valid = '0;
    tick();
    chk("nand_op_count", 32'(op_count), 32'd4);
    chk("nand_drained", 32'(rsp_valid), 32'h0);

    // Round robin, all requesters valid, no bubbles.
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("rr_order", 32'(rsp_id), 32'(order[i]));
    end

    // Back-pressure: hold requester 1's result, then drain and accept 3 together.
    req_valid = '0;
    do_reset();
    req_valid = 4'b0010;
    req_a = 4'b0010; req_b = 4'b0010;
    tick();
    req_valid = 4'b1011;
    req_a = 4'b0011; req_b = 4'b0011;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h0);
      chk("bp_rsp_id", 32'(rsp_id), 32'h1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant3", 32'(req_ready), 32'h8);
    tick();
    chk("bp_next_id", 32'(rsp_id), 32'h3);
    chk("bp_next_data", 32'(rsp_data), 32'h1);
    chk("bp_op_count", 32'(op_count), 32'd1);

    // Reset mid-operation discards the pending result.
    req_valid = '0;
    do_reset();
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    chk("mid_pending", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_op_count", 32'(op_count), 32'h0);
    rsp_ready = 1'b1;
    tick();
    chk("mid_no_response", 32'(rsp_valid), 32'h0);
    chk("mid_no_count", 32'(op_count), 32'h0);
    req_valid = '1;
    #1;
    chk("mid_ptr_zero", 32'(req_ready), 32'h1);

    // Randomized traffic honoring the hold-until-ready requester protocol.
    req_valid = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_last_acc == i) begin
          req_valid[i]     = 1'($urandom_range(0, 1));
          req_a[i*W +: W]  = W'($urandom);
          req_b[i*W +: W]  = W'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Saturation of the completion counter.
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 65540; c++) tick();
    chk("sat_op_count", 32'(op_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/nand_rr_arbiter.md
Name: nand_rr_arbiter

Overview:
- Shares one registered bitwise-NAND evaluation unit among NUM_REQ requesters.
- Uses round-robin arbitration with valid/ready handshakes on every requester port and on the single response port.
- Returns each result tagged with the requester ID, and keeps a saturating count of completed operations.
- Sits between the tile's input decode and the NAND datapath; it is the only path into that unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 1, operand/result width in bits; NAND is bitwise.
- ID_W, clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand A; slice i belongs to requester i.
- req_b  input  NUM_REQ*WIDTH  operand B; slice i belongs to requester i.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  WIDTH  ~(a & b) of the accepted request.
- rsp_id  output  ID_W  index of the requester that produced rsp_data.
- op_count  output  16  completed responses, saturating.
- busy  output  1  rsp_valid OR any req_valid.

Behaviour:
- Reset:
  - rsp_valid=0, rsp_data=0, rsp_id=0, op_count=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
  - req_ready=0 during every cycle rst is high.
  - Reset asserted mid-operation discards any pending result with no response.
- can_accept = !rsp_valid OR rsp_ready. The single-entry result register is empty or is draining this cycle.
- Grant selection (combinational):
  - Scan requesters ptr, ptr+1, ..., ptr+NUM_REQ-1 modulo NUM_REQ.
  - The first one with req_valid=1 wins: gnt_idx.
  - req_ready[gnt_idx]=can_accept; all other req_ready bits are 0.
  - No valid requester means req_ready is all 0.
- Accept happens on a clock edge where req_valid[i] AND req_ready[i]. At that edge:
  - rsp_data <= ~(req_a[i] & req_b[i]).
  - rsp_id <= i.
  - rsp_valid <= 1.
  - ptr <= (i+1) mod NUM_REQ.
- Latency and throughput:
  - An accepted request appears on rsp_* the next cycle.
  - Throughput is 1 op/cycle while rsp_ready=1.
- Drain without a new accept: an edge with rsp_valid AND rsp_ready sets rsp_valid <= 0. rsp_data and rsp_id keep their last values.
- Simultaneous drain and accept: the result register is overwritten with the new result and rsp_valid stays 1. No bubble.
- Back-pressure:
  - While rsp_valid=1 and rsp_ready=0, rsp_data, rsp_id and rsp_valid are held stable.
  - req_ready stays all 0 in that state.
- ptr changes only on accept. Idle cycles and stall cycles do not rotate priority.
- Fairness: a requester holding req_valid is granted within NUM_REQ accepts.
- Requester protocol: once req_valid is asserted, it and the operands stay stable until req_ready. The arbiter does not check this.
- op_count increments on each rsp_valid AND rsp_ready edge and saturates at 0xFFFF.
- Wrap-around: the ptr update from NUM_REQ-1 goes to 0.
- No explicit FSM. State = {rsp_valid, ptr}: EMPTY (rsp_valid=0) and FULL (rsp_valid=1), with transitions as above.

Decomposition:
- Shared package nand_arb_pkg holds:
  - the NUM_REQ default;
  - the ID_W function (clog2);
  - the op_count width constant (16) and the saturation value.
- One sub-module, rr_pick: combinational rotate-by-ptr first-one picker.
  - Inputs: valid vector and ptr.
  - Outputs: one-hot grant, gnt_idx, any_valid.
- The NAND evaluation and the result register stay in the top module.

Test Plan:
1. Reset check: rst high for 2 cycles with all req_valid=1 -> req_ready=0000, rsp_valid=0, op_count=0; the first cycle after reset grants requester 0.
2. NAND truth table, NUM_REQ=4, WIDTH=1, requester 2 only, rsp_ready=1: (a,b)=(0,0),(0,1),(1,0),(1,1) -> rsp_data=1,1,1,0, rsp_id=2 each time, one cycle after accept; op_count=4.
3. Round-robin with all four requesters valid and rsp_ready held 1 -> accept order 0,1,2,3,0,1; a result every cycle with no bubbles.
4. Back-pressure: accept requester 1, then rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_id stay constant; req_ready=0000; ptr unchanged. Raise rsp_ready -> drain and accept the next requester on the same edge.
5. Reset mid-operation: rsp_valid=1 with rsp_ready=0, then assert rst for 1 cycle -> rsp_valid=0, ptr=0, op_count=0, and no response is emitted for the pending result.
6. Saturation: force 65537 drains (or preload via a test hook) -> op_count stops at 0xFFFF.
